fp_unpack_norm: RTL and testbench

Parametrised, pipelined floating-point operand unpacker for the FMA datapath. It accepts one packed IEEE-754 binary operand per cycle over a valid/ready handshake. It classifies the operand and fully normalises subnormals with a leading-zero count and left shift, so downstream multiply/align logic always receives a mantissa with its leading one in the MSB. It adds an optional flush-to-zero mode and a sticky invalid flag for signalling NaNs.

---
 rtl/fp_unpack_norm.sv | 172 +++++++++++++++++
 tb/tb_fp_unpack_norm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unpack_norm.sv
// rtl/fp_unpack_norm.sv - two-stage IEEE-754 operand unpacker with subnormal normalisation
module fp_unpack_norm #(
    parameter int EW = 5,
    parameter int FW = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW+FW:0]      in_x,
    input  logic                in_ftz,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_s,
    output logic [EW+1:0]       out_e,
    output logic [FW:0]         out_m,
    output logic                out_subnorm,
    output logic                out_zero,
    output logic                out_inf,
    output logic                out_nan,
    output logic                out_snan,
    output logic                nv_sticky,
    input  logic                flags_clr
);
    localparam int LZW = $clog2(FW + 1);

    logic s2_load;
    logic s1_load;
    logic in_fire;

    logic          s1_valid_q;
    logic          s1_s_q;
    logic [FW-1:0] s1_f_q;
    logic          s1_emax_q;
    logic          s1_enz_q;
    logic [EW-1:0] s1_e_q;
    logic          s1_sub_q, s1_zero_q, s1_inf_q, s1_nan_q, s1_snan_q;
    logic          s1_ftz_q;
    logic [LZW-1:0] s1_lzc_q;

    logic          s2_valid_q;
    logic          s2_s_q;
    logic [EW+1:0] s2_e_q, s2_e_d;
    logic [FW:0]   s2_m_q, s2_m_d;
    logic          s2_sub_q, s2_zero_q, s2_zero_d, s2_inf_q, s2_nan_q, s2_snan_q;
    logic          sticky_q, sticky_d;

    logic          x_s;
    logic [EW-1:0] x_e;
    logic [FW-1:0] x_f;
    logic          x_emax, x_enz, x_fz;
    logic [LZW-1:0] x_lzc;
    logic [FW:0]   f_ext;

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid & s1_load;

    assign x_s    = in_x[EW+FW];
    assign x_e    = in_x[FW +: EW];
    assign x_f    = in_x[FW-1:0];
    assign x_emax = &x_e;
    assign x_enz  = |x_e;
    assign x_fz   = ~|x_f;

    // Ascending scan: the highest set bit is visited last and sets the count.
    always_comb begin
        x_lzc = '0;
        for (int i = 0; i < FW; i++) begin
            if (x_f[i]) begin
                x_lzc = LZW'(FW - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= 1'b0;
            s1_f_q     <= '0;
            s1_e_q     <= '0;
            s1_emax_q  <= 1'b0;
            s1_enz_q   <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_snan_q  <= 1'b0;
            s1_ftz_q   <= 1'b0;
            s1_lzc_q   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                s1_s_q    <= x_s;
                s1_f_q    <= x_f;
                s1_e_q    <= x_e;
                s1_emax_q <= x_emax;
                s1_enz_q  <= x_enz;
                s1_sub_q  <= ~x_enz & ~x_fz;
                s1_zero_q <= ~x_enz & x_fz;
                s1_inf_q  <= x_emax & x_fz;
                s1_nan_q  <= x_emax & ~x_fz;
                s1_snan_q <= x_emax & ~x_fz & ~x_f[FW-1];
                s1_ftz_q  <= in_ftz;
                s1_lzc_q  <= x_lzc;
            end
        end
    end

    // Subnormals shift their leading one into the MSB; exponent becomes -lzc.
    always_comb begin
        f_ext     = {1'b0, s1_f_q};
        s2_e_d    = '0;
        s2_m_d    = '0;
        s2_zero_d = s1_zero_q | (s1_sub_q & s1_ftz_q);
        if (s1_sub_q && !s1_ftz_q) begin
            s2_m_d = f_ext << (s1_lzc_q + 1'b1);
            s2_e_d = (EW+2)'(0) - (EW+2)'(s1_lzc_q);
        end else if (s1_enz_q || s1_emax_q) begin
            s2_m_d = {1'b1, s1_f_q};
            s2_e_d = (EW+2)'(s1_e_q);
        end
    end

    assign sticky_d = (out_valid & out_ready & out_snan) ? 1'b1 :
                      flags_clr                          ? 1'b0 : sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_s_q     <= 1'b0;
            s2_e_q     <= '0;
            s2_m_q     <= '0;
            s2_sub_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_nan_q   <= 1'b0;
            s2_snan_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load && s1_valid_q) begin
                s2_s_q    <= s1_s_q;
                s2_e_q    <= s2_e_d;
                s2_m_q    <= s2_m_d;
                s2_sub_q  <= s1_sub_q;
                s2_zero_q <= s2_zero_d;
                s2_inf_q  <= s1_inf_q;
                s2_nan_q  <= s1_nan_q;
                s2_snan_q <= s1_snan_q;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_s       = s2_s_q;
    assign out_e       = s2_e_q;
    assign out_m       = s2_m_q;
    assign out_subnorm = s2_sub_q;
    assign out_zero    = s2_zero_q;
    assign out_inf     = s2_inf_q;
    assign out_nan     = s2_nan_q;
    assign out_snan    = s2_snan_q;
    assign nv_sticky   = sticky_q;

endmodule

// File: tb/tb_fp_unpack_norm.sv
// tb/tb_fp_unpack_norm.sv - scoreboard bench for fp_unpack_norm against an arithmetic reference model
module tb_fp_unpack_norm;
    localparam int EW = 5;
    localparam int FW = 10;
    localparam int XW = EW + FW + 1;

    typedef struct packed {
        logic          s;
        logic [EW+1:0] e;
        logic [FW:0]   m;
        logic          sub;
        logic          zero;
        logic          inf;
        logic          nan;
        logic          snan;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] in_x = '0;
    logic          in_ftz = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_s;
    logic [EW+1:0] out_e;
    logic [FW:0]   out_m;
    logic          out_subnorm, out_zero, out_inf, out_nan, out_snan;
    logic          nv_sticky;
    logic          flags_clr = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    res_t sb[$];
    logic sticky_model = 1'b0;
    logic prev_stall = 1'b0;
    logic [XW+9:0] prev_bus = '0;
    int   rdy_mode = 0;
    int   clr_mode = 0;

    fp_unpack_norm #(.EW(EW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_ftz(in_ftz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_m(out_m),
        .out_subnorm(out_subnorm), .out_zero(out_zero), .out_inf(out_inf),
        .out_nan(out_nan), .out_snan(out_snan),
        .nv_sticky(nv_sticky), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Normalise by repeated doubling; each doubling lowers the exponent by one from 1.
    function automatic res_t model(input logic [XW-1:0] x, input logic ftz);
        res_t r;
        int e_f, f, m, k;
        r = '0;
        r.s = x[XW-1];
        e_f = int'(x[FW +: EW]);
        f = int'(x[FW-1:0]);
        if (e_f == (1 << EW) - 1) begin
            r.e = (EW+2)'(e_f);
            r.m = (FW+1)'((1 << FW) + f);
            r.inf = (f == 0);
            r.nan = (f != 0);
            r.snan = (f != 0) && (f < (1 << (FW - 1)));
        end else if (e_f != 0) begin
            r.e = (EW+2)'(e_f);
            r.m = (FW+1)'((1 << FW) + f);
        end else if (f == 0) begin
            r.zero = 1'b1;
        end else if (ftz) begin
            r.zero = 1'b1;
            r.sub = 1'b1;
        end else begin
            m = f;
            k = 0;
            while (m < (1 << FW)) begin
                m = m * 2;
                k++;
            end
            r.sub = 1'b1;
            r.m = (FW+1)'(m);
            r.e = (EW+2)'(1 - k);
        end
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        res_t act, exp;
        logic set;
        logic [XW+9:0] bus;
        if (rst_n) begin
            chk("nv_sticky", 64'(nv_sticky), 64'(sticky_model));
            chk("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
            bus = {out_valid, out_s, out_e, out_m, out_subnorm, out_zero, out_inf, out_nan, out_snan};
            if (prev_stall) chk("stall_hold", 64'(bus), 64'(prev_bus));
            prev_stall = out_valid & ~out_ready;
            prev_bus = bus;
            set = 1'b0;
            if (out_valid && out_ready) begin
                act = '{out_s, out_e, out_m, out_subnorm, out_zero, out_inf, out_nan, out_snan};
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(act), 64'(0) - 64'(1));
                end else begin
                    exp = sb.pop_front();
                    chk("out", 64'(act), 64'(exp));
                    set = exp.snan;
                end
            end
            sticky_model = set ? 1'b1 : (flags_clr ? 1'b0 : sticky_model);
            if (in_valid && in_ready) sb.push_back(model(in_x, in_ftz));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            case (clr_mode)
                0: flags_clr = 1'b0;
                1: flags_clr = ($urandom_range(0, 7) == 0);
                default: flags_clr = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [XW-1:0] x, input logic ftz);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_ftz = ftz;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = XW'($urandom);
        in_ftz = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XW-1:0] rand_op();
        logic [XW-1:0] x;
        x = XW'($urandom);
        case ($urandom_range(0, 5))
            0: begin
                x[FW +: EW] = '0;
                if (x[FW-1:0] == 0) x[0] = 1'b1;
            end
            1: x[XW-2:0] = '0;
            2: x[FW +: EW] = '1;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        logic [XW-1:0] dir_x [12];
        logic          dir_f [12];
        dir_x = '{16'h3C00, 16'h0001, 16'h0200, 16'h8001, 16'h7C01, 16'h7E00,
                  16'h7C00, 16'h0000, 16'h8000, 16'h3C00, 16'h7C01, 16'h03FF};
        dir_f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'({out_s, out_e, out_m}), 64'(0));
        chk("rst_flags", 64'({out_subnorm, out_zero, out_inf, out_nan, out_snan, nv_sticky}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 0;
        for (int i = 0; i < 12; i++) send(dir_x[i], dir_f[i]);
        drain();
        chk("sticky_after_snan", 64'(nv_sticky), 64'(1));

        // Hold clear high while an sNaN is delivered: the set must win.
        clr_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        send(16'h7C01, 1'b0);
        drain();
        clr_mode = 0;

        rdy_mode = 1;
        clr_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_op(), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();
        clr_mode = 0;

        send(16'h7C01, 1'b0);
        drain();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(16'h3C00, 1'b0);
        send(16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("pipe_full_stall", 64'({out_valid, in_ready, nv_sticky}), 64'(3'b101));
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_sticky", 64'(nv_sticky), 64'(0));
        sb.delete();
        sticky_model = 1'b0;
        prev_stall = 1'b0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send(16'h0200, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
